dlatch_wr_sched: RTL and testbench

DLATCH_WR_SCHED -- requirements
Module: dlatch_wr_sched

---
 rtl/dlatch_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/dlatch_wr_sched.sv | 92 +++++++++
 tb/tb_dlatch_wr_sched.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlatch_pkg.sv
// Shared types and constants for the D-latch write scheduler.
// The state encoding and the fixed SETUP/HOLD durations live here.
package dlatch_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SETUP,
        OPEN,
        HOLD,
        CHECK
    } state_t;

    localparam int unsigned SETUP_CYC = 1;
    localparam int unsigned HOLD_CYC  = 1;
    localparam int unsigned IDX_W     = 3;
    localparam int unsigned CNT_W     = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: the search starts at ptr and wraps.
// Returns the one-hot winner and its index; the pointer is held by the parent.
module rr_arbiter
    import dlatch_pkg::*;
#(
    parameter int unsigned NREQ = 4
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    output logic [NREQ-1:0]  winner,
    output logic [IDX_W-1:0] index
);

    logic            w_found;
    logic [NREQ-1:0] w_rot;
    int unsigned     w_k;

    always_comb begin
        winner  = '0;
        index   = '0;
        w_found = 1'b0;
        w_rot   = '0;
        w_k     = 0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            w_k   = (32'(ptr) + i) % NREQ;
            w_rot = req >> w_k;
            if (!w_found && w_rot[0]) begin
                w_found = 1'b1;
                winner  = NREQ'(1) << w_k;
                index   = IDX_W'(w_k);
            end
        end
    end

endmodule

// File: rtl/dlatch_wr_sched.sv
// Schedules writes from NREQ requesters into one shared D-latch bank with
// setup, enable, hold and readback-check phases.
module dlatch_wr_sched
    import dlatch_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned W      = 8,
    parameter int unsigned EN_CYC = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic [W-1:0]      lat_d,
    output logic              lat_en,
    input  logic [W-1:0]      lat_q,
    output logic              done,
    output logic [IDX_W-1:0]  done_id,
    output logic              err
);

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [IDX_W-1:0] r_ptr;
    logic [IDX_W-1:0] r_idx;
    logic [W-1:0]     r_lat_d;
    logic             r_lat_en;

    logic [NREQ-1:0]  w_winner;
    logic [IDX_W-1:0] w_index;
    logic [IDX_W-1:0] w_ptr_nxt;
    logic [W-1:0]     w_slice;
    logic             w_grant;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req    (req),
        .ptr    (r_ptr),
        .winner (w_winner),
        .index  (w_index)
    );

    assign w_grant   = (r_state == IDLE) && (|req) && !rst;
    assign w_slice   = W'(req_data >> (32'(w_index) * W));
    assign w_ptr_nxt = (32'(w_index) == NREQ - 1) ? '0 : w_index + 1'b1;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|req) w_state_nxt = SETUP;
            SETUP:   if (32'(r_cnt) == SETUP_CYC - 1) w_state_nxt = OPEN;
            OPEN:    if (32'(r_cnt) == EN_CYC - 1) w_state_nxt = HOLD;
            HOLD:    if (32'(r_cnt) == HOLD_CYC - 1) w_state_nxt = CHECK;
            CHECK:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // One counter times every phase; it restarts on each state change.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_ptr    <= '0;
            r_idx    <= '0;
            r_lat_d  <= '0;
            r_lat_en <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if ((w_state_nxt != r_state) || (r_state == IDLE)) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            r_lat_en <= (w_state_nxt == OPEN);
            if (w_grant) begin
                r_lat_d <= w_slice;
                r_idx   <= w_index;
                r_ptr   <= w_ptr_nxt;
            end
        end
    end

    assign gnt     = w_grant ? w_winner : '0;
    assign lat_d   = r_lat_d;
    assign lat_en  = r_lat_en;
    assign done    = (r_state == CHECK) && !rst;
    assign done_id = done ? r_idx : '0;
    assign err     = done && (lat_q != r_lat_d);

endmodule

// File: tb/tb_dlatch_wr_sched.sv
// Directed bench for dlatch_wr_sched: three instances (EN_CYC 2, 1, 15)
// share clock, reset and data, each driving its own behavioural latch bank.
module tb_dlatch_wr_sched;

    localparam int unsigned N  = 4;
    localparam int unsigned DW = 8;
    localparam int          LG = 40;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req     [3];
    logic [N-1:0]    gnt     [3];
    logic [DW-1:0]   lat_d   [3];
    logic [DW-1:0]   lat_q   [3];
    logic [DW-1:0]   latch   [3];
    logic            lat_en  [3];
    logic            done    [3];
    logic            err     [3];
    logic [2:0]      done_id [3];
    logic            force_zero;

    int total = 0;
    int bad   = 0;

    dlatch_wr_sched #(.NREQ(4), .W(8), .EN_CYC(2)) u_dut (
        .clk(clk), .rst(rst), .req(req[0]), .req_data(req_data), .gnt(gnt[0]),
        .lat_d(lat_d[0]), .lat_en(lat_en[0]), .lat_q(lat_q[0]),
        .done(done[0]), .done_id(done_id[0]), .err(err[0])
    );
    dlatch_wr_sched #(.NREQ(4), .W(8), .EN_CYC(1)) u_e1 (
        .clk(clk), .rst(rst), .req(req[1]), .req_data(req_data), .gnt(gnt[1]),
        .lat_d(lat_d[1]), .lat_en(lat_en[1]), .lat_q(lat_q[1]),
        .done(done[1]), .done_id(done_id[1]), .err(err[1])
    );
    dlatch_wr_sched #(.NREQ(4), .W(8), .EN_CYC(15)) u_e15 (
        .clk(clk), .rst(rst), .req(req[2]), .req_data(req_data), .gnt(gnt[2]),
        .lat_d(lat_d[2]), .lat_en(lat_en[2]), .lat_q(lat_q[2]),
        .done(done[2]), .done_id(done_id[2]), .err(err[2])
    );

    // Transparent-high latch banks; force_zero models a stuck readback.
    always_latch begin
        if (lat_en[0]) latch[0] <= lat_d[0];
        if (lat_en[1]) latch[1] <= lat_d[1];
        if (lat_en[2]) latch[2] <= lat_d[2];
    end

    always_comb begin
        for (int i = 0; i < 3; i++) begin
            lat_q[i] = force_zero ? '0 : latch[i];
        end
    end

    logic [N-1:0]  lg_gnt  [3][LG];
    logic          lg_en   [3][LG];
    logic          lg_done [3][LG];
    logic          lg_err  [3][LG];
    logic [2:0]    lg_id   [3][LG];
    logic [DW-1:0] lg_d    [3][LG];
    logic [N-1:0]  g_gnt   [3];

    int            a_first_en, a_en_w, a_first_done, a_ndone, a_nerr;
    logic [2:0]    a_id;
    logic          a_err;
    logic [N-1:0]  a_gnt_or;
    logic [DW-1:0] a_d;
    logic [N-1:0]  gacc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic record(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            for (int s = 0; s < 3; s++) begin
                lg_gnt[s][k]  = gnt[s];
                lg_en[s][k]   = lat_en[s];
                lg_done[s][k] = done[s];
                lg_err[s][k]  = err[s];
                lg_id[s][k]   = done_id[s];
                lg_d[s][k]    = lat_d[s];
            end
        end
    endtask

    task automatic analyze(input int s, input int n);
        a_first_en = -1; a_en_w = 0; a_first_done = -1; a_ndone = 0; a_nerr = 0;
        a_id = '0; a_err = 1'b0; a_gnt_or = '0; a_d = '0;
        for (int k = 0; k < n; k++) begin
            if (lg_en[s][k] === 1'b1) begin
                if (a_first_en < 0) a_first_en = k;
                a_en_w++;
            end
            if (lg_done[s][k] === 1'b1) begin
                if (a_first_done < 0) begin
                    a_first_done = k;
                    a_id  = lg_id[s][k];
                    a_err = lg_err[s][k];
                    a_d   = lg_d[s][k];
                end
                a_ndone++;
            end
            if (lg_err[s][k] === 1'b1) a_nerr++;
            a_gnt_or = a_gnt_or | lg_gnt[s][k];
        end
    endtask

    // Raise requests for one cycle, capture the grant, then drop them.
    task automatic issue(input logic [N-1:0] r0, input logic [N-1:0] r1, input logic [N-1:0] r2);
        @(posedge clk); #1;
        req[0] = r0; req[1] = r1; req[2] = r2;
        @(negedge clk);
        for (int s = 0; s < 3; s++) g_gnt[s] = gnt[s];
        @(posedge clk); #1;
        req[0] = '0; req[1] = '0; req[2] = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst        = 1'b1;
        force_zero = 1'b0;
        req_data   = 32'h3CA52211;
        req[0] = 4'b1111; req[1] = '0; req[2] = '0;

        // Reset, with requests pending: reset must win.
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("gnt_during_rst", 32'(gnt[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0; req[0] = '0;
        @(negedge clk);
        chk("rst_gnt", 32'(gnt[0]), 0);
        chk("rst_lat_en", 32'(lat_en[0]), 0);
        chk("rst_lat_d", 32'(lat_d[0]), 0);
        chk("rst_done", 32'(done[0]), 0);
        chk("rst_done_id", 32'(done_id[0]), 0);
        chk("rst_err", 32'(err[0]), 0);

        // Single request from requester 2 (ptr 0 -> 3).
        issue(4'b0100, '0, '0);
        chk("single_gnt", 32'(g_gnt[0]), 32'h4);
        record(8);
        analyze(0, 8);
        chk("single_lat_d_setup", 32'(lg_d[0][0]), 32'hA5);
        chk("single_en_start", a_first_en, 1);
        chk("single_en_width", a_en_w, 2);
        chk("single_done_lat", a_first_done, 4);
        chk("single_done_cnt", a_ndone, 1);
        chk("single_done_id", 32'(a_id), 2);
        chk("single_err", 32'(a_err), 0);
        chk("single_lat_d_hold", 32'(a_d), 32'hA5);
        chk("single_no_regrant", 32'(a_gnt_or), 0);

        // Readback mismatch on requester 3 (ptr 3 -> 0).
        force_zero = 1'b1;
        issue(4'b1000, '0, '0);
        chk("mism_gnt", 32'(g_gnt[0]), 32'h8);
        record(8);
        force_zero = 1'b0;
        analyze(0, 8);
        chk("mism_done_lat", a_first_done, 4);
        chk("mism_err_at_done", 32'(a_err), 1);
        chk("mism_err_cnt", a_nerr, 1);
        chk("mism_done_id", 32'(a_id), 3);
        chk("mism_lat_d", 32'(a_d), 32'h3C);

        // Fairness: all four held, one grant every EN_CYC+4 cycles.
        @(posedge clk); #1;
        req[0] = 4'b1111;
        record(25);
        analyze(0, 25);
        chk("fair_g0", 32'(lg_gnt[0][0]), 32'h1);
        chk("fair_g1", 32'(lg_gnt[0][6]), 32'h2);
        chk("fair_g2", 32'(lg_gnt[0][12]), 32'h4);
        chk("fair_g3", 32'(lg_gnt[0][18]), 32'h8);
        chk("fair_g4", 32'(lg_gnt[0][24]), 32'h1);
        begin
            int ng;
            ng = 0;
            for (int k = 0; k < 25; k++) if (lg_gnt[0][k] !== 4'b0000) ng++;
            chk("fair_grant_count", ng, 5);
        end
        @(posedge clk); #1;
        req[0] = '0;
        record(8);
        analyze(0, 8);
        chk("fair_tail_done", a_first_done, 4);
        chk("fair_tail_id", 32'(a_id), 0);

        // Requester 1 pulses only while OPEN: never granted (ptr 1 -> 3).
        issue(4'b0100, '0, '0);
        chk("drop_first_gnt", 32'(g_gnt[0]), 32'h4);
        @(negedge clk);
        gacc = gnt[0];
        @(posedge clk); #1;
        req[0] = 4'b0010;
        @(negedge clk);
        gacc = gacc | gnt[0];
        chk("drop_open_en", 32'(lat_en[0]), 1);
        @(posedge clk); #1;
        @(negedge clk);
        gacc = gacc | gnt[0];
        @(posedge clk); #1;
        req[0] = '0;
        record(10);
        analyze(0, 10);
        chk("drop_never_granted", 32'(gacc | a_gnt_or), 0);
        chk("drop_done_lat", a_first_done, 1);
        chk("drop_done_id", 32'(a_id), 2);

        // Reset during OPEN: write abandoned, ptr back to 0 (was 3).
        issue(4'b0100, '0, '0);
        chk("rmid_gnt", 32'(g_gnt[0]), 32'h4);
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rmid_open_en", 32'(lat_en[0]), 1);
        chk("rmid_done_in_rst", 32'(done[0]), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rmid_en_drop", 32'(lat_en[0]), 0);
        record(8);
        analyze(0, 8);
        chk("rmid_no_done", a_ndone, 0);
        chk("rmid_no_en", a_en_w, 0);
        chk("rmid_no_err", a_nerr, 0);
        issue(4'b1010, '0, '0);
        chk("rmid_ptr0_gnt", 32'(g_gnt[0]), 32'h2);
        record(8);
        analyze(0, 8);
        chk("rmid_post_done", a_first_done, 4);
        chk("rmid_post_id", 32'(a_id), 1);
        chk("rmid_post_err", 32'(a_err), 0);
        chk("rmid_post_d", 32'(a_d), 32'h22);

        // EN_CYC sweep on the 1- and 15-cycle instances.
        issue('0, 4'b0001, 4'b0001);
        chk("e1_gnt", 32'(g_gnt[1]), 32'h1);
        chk("e15_gnt", 32'(g_gnt[2]), 32'h1);
        record(24);
        analyze(1, 24);
        chk("e1_en_start", a_first_en, 1);
        chk("e1_en_width", a_en_w, 1);
        chk("e1_done_lat", a_first_done, 3);
        chk("e1_err", 32'(a_err), 0);
        analyze(2, 24);
        chk("e15_en_start", a_first_en, 1);
        chk("e15_en_width", a_en_w, 15);
        chk("e15_done_lat", a_first_done, 17);
        chk("e15_done_cnt", a_ndone, 1);
        chk("e15_err", 32'(a_err), 0);
        chk("e15_d", 32'(a_d), 32'h11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
